// File: rtl/cpu19_pkg.sv
// Shared constants and types for the 19-bit CPU execution controller:
// opcode encodings, instruction field positions and the controller state enum.
package cpu19_pkg;

    localparam int W = 19;

    localparam logic [4:0] OP_NOP = 5'b00000;
    localparam logic [4:0] OP_ADD = 5'b00001;
    localparam logic [4:0] OP_SUB = 5'b00010;
    localparam logic [4:0] OP_MUL = 5'b00011;
    localparam logic [4:0] OP_DIV = 5'b00100;
    localparam logic [4:0] OP_INC = 5'b00101;
    localparam logic [4:0] OP_DEC = 5'b00110;
    localparam logic [4:0] OP_AND = 5'b00111;
    localparam logic [4:0] OP_OR  = 5'b01000;
    localparam logic [4:0] OP_XOR = 5'b01001;
    localparam logic [4:0] OP_NOT = 5'b01010;
    localparam logic [4:0] OP_LDI = 5'b01011;

    localparam int OP_HI  = 18;
    localparam int OP_LO  = 14;
    localparam int RD_HI  = 13;
    localparam int RD_LO  = 11;
    localparam int RS1_HI = 10;
    localparam int RS1_LO = 8;
    localparam int RS2_HI = 7;
    localparam int RS2_LO = 5;
    localparam int IMM_HI = 10;
    localparam int IMM_LO = 0;
    localparam int IMM_W  = IMM_HI - IMM_LO + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_t;

    // Opcodes that are routed through the external ALU.
    function automatic logic is_alu_op(input logic [4:0] op);
        return (op >= OP_ADD) && (op <= OP_NOT);
    endfunction

endpackage

// File: rtl/cpu19_regfile.sv
// 8x19 register file: two combinational operand reads, one debug read,
// one synchronous write port, asynchronous active-low clear.
module cpu19_regfile
    import cpu19_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int DW    = W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [2:0]    waddr,
    input  logic [DW-1:0] wdata,
    input  logic [2:0]    raddr1,
    input  logic [2:0]    raddr2,
    input  logic [2:0]    dbg_addr,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2,
    output logic [DW-1:0] dbg_data
);

    logic [DW-1:0] mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1   = mem[raddr1];
    assign rdata2   = mem[raddr2];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/cpu19_exec_ctrl.sv
// Instruction issue / write-back controller for the 19-bit CPU; drives the
// external combinational ALU and retires one instruction at a time.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | instr_ready high, waiting for instr_valid
// ST_DECODE | read rs1/rs2, load ALU operands or route to WB (skip/error)
// ST_EXEC   | capture ALU result and flags
// ST_WB     | done pulse, register write and flag update at exit edge
module cpu19_exec_ctrl #(
    parameter int NREGS = 8,
    parameter int W     = 19
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] instr,
    input  logic         instr_valid,
    output logic         instr_ready,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [4:0]   alu_opcode,
    input  logic [W-1:0] alu_result,
    input  logic         alu_zero,
    input  logic         alu_negative,
    output logic         flag_z,
    output logic         flag_n,
    output logic         done,
    output logic         err,
    input  logic [2:0]   dbg_addr,
    output logic [W-1:0] dbg_data
);
    import cpu19_pkg::*;

    state_t         state;
    logic [W-1:0]   instr_q;
    logic [W-1:0]   res_q;
    logic           res_z_q;
    logic           res_n_q;
    logic           err_pend;
    logic           wb_alu;

    logic [4:0]     op_q;
    logic [2:0]     rd_q;
    logic [2:0]     rs1_q;
    logic [2:0]     rs2_q;
    logic [W-1:0]   imm_q;
    logic [W-1:0]   rdata1;
    logic [W-1:0]   rdata2;
    logic           wr_en;
    logic [W-1:0]   wr_data;

    assign op_q  = instr_q[OP_HI:OP_LO];
    assign rd_q  = instr_q[RD_HI:RD_LO];
    assign rs1_q = instr_q[RS1_HI:RS1_LO];
    assign rs2_q = instr_q[RS2_HI:RS2_LO];
    assign imm_q = {{(W-IMM_W){1'b0}}, instr_q[IMM_HI:IMM_LO]};

    assign instr_ready = (state == ST_IDLE);

    // Commit happens on the edge that leaves WB; errors and NOP never write.
    assign wr_en   = (state == ST_WB) && !err_pend && (wb_alu || (op_q == OP_LDI));
    assign wr_data = wb_alu ? res_q : imm_q;

    cpu19_regfile #(
        .NREGS (NREGS),
        .DW    (W)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (wr_en),
        .waddr    (rd_q),
        .wdata    (wr_data),
        .raddr1   (rs1_q),
        .raddr2   (rs2_q),
        .dbg_addr (dbg_addr),
        .rdata1   (rdata1),
        .rdata2   (rdata2),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            instr_q    <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= OP_NOP;
            res_q      <= '0;
            res_z_q    <= 1'b0;
            res_n_q    <= 1'b0;
            err_pend   <= 1'b0;
            wb_alu     <= 1'b0;
            flag_z     <= 1'b0;
            flag_n     <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                        state   <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    err_pend <= 1'b0;
                    wb_alu   <= 1'b0;
                    if (is_alu_op(op_q) && !((op_q == OP_DIV) && (rdata2 == '0))) begin
                        alu_a      <= rdata1;
                        alu_b      <= rdata2;
                        alu_opcode <= op_q;
                        wb_alu     <= 1'b1;
                        state      <= ST_EXEC;
                    end else begin
                        // Skip paths: divide-by-zero, illegal, NOP and LDI.
                        alu_opcode <= OP_NOP;
                        done       <= 1'b1;
                        state      <= ST_WB;
                        if (is_alu_op(op_q) || (op_q > OP_LDI)) begin
                            err_pend <= 1'b1;
                            err      <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    res_q   <= alu_result;
                    res_z_q <= alu_zero;
                    res_n_q <= alu_negative;
                    done    <= 1'b1;
                    err     <= err_pend;
                    state   <= ST_WB;
                end
                ST_WB: begin
                    if (wb_alu && !err_pend) begin
                        flag_z <= res_z_q;
                        flag_n <= res_n_q;
                    end
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
